// File: rtl/jc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jc_pkg
// Description : Shared constants and legality/phase helpers for jc_seq_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package jc_pkg;

    localparam int   c_MAX_W      = 64;
    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam logic DIR_FWD      = 1'b0;
    localparam logic DIR_REV      = 1'b1;

    // Johnson states are thermometer codes: at most one 0/1 edge between neighbours.
    function automatic logic is_legal(input logic [c_MAX_W-1:0] q, input int w, input logic mode);
        int ones;
        int edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if ((i < w) && q[i]) begin
                ones++;
            end
        end
        for (int i = 0; i < c_MAX_W - 1; i++) begin
            if ((i + 1 < w) && (q[i] != q[i+1])) begin
                edges++;
            end
        end
        if (mode == MODE_RING) begin
            return (ones == 1);
        end
        return (edges <= 1);
    endfunction

    function automatic int phase_of(input logic [c_MAX_W-1:0] q, input int w, input logic mode);
        int ones;
        int idx;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if ((i < w) && q[i]) begin
                ones++;
                idx = i;
            end
        end
        if (!is_legal(q, w, mode)) begin
            return 0;
        end
        if (mode == MODE_RING) begin
            return idx;
        end
        if (q[w-1]) begin
            return 2 * w - ones;
        end
        return ones;
    endfunction

    function automatic logic [c_MAX_W-1:0] reset_val(input logic mode);
        return {{(c_MAX_W-1){1'b0}}, (mode == MODE_RING)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jc_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : jc_prescaler
// Description : Enable-gated divide-by-(div+1) counter producing a step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module jc_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             clear,
    output logic             step
);

    logic [DIV_W-1:0] r_cnt;

    assign step = en && (r_cnt == div);

    // A div lowered below r_cnt simply lets the count run round modulo 2^DIV_W.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == div) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/jc_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : jc_seq_gen
// Description : Parametrised Johnson/ring sequence generator with prescaler,
//               legalising load, self-correction, phase decode and strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module jc_seq_gen
    import jc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8,
    parameter int PH_W  = $clog2(2*WIDTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  phase,
    output logic             tick,
    output logic             wrap,
    output logic             illegal
);

    localparam int c_LAST_J = 2 * WIDTH - 1;
    localparam int c_LAST_R = WIDTH - 1;

    logic             w_step;
    logic [WIDTH-1:0] r_q;
    logic             r_tick;
    logic             r_wrap;
    logic [WIDTH-1:0] w_rst_val;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_load_q;
    logic [PH_W-1:0]  w_next_phase;
    logic             w_next_wrap;

    jc_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .en    (en),
        .div   (div),
        .clear (load),
        .step  (w_step)
    );

    assign w_rst_val = WIDTH'(reset_val(mode));
    assign illegal   = !is_legal(c_MAX_W'(r_q), WIDTH, mode);
    assign phase     = PH_W'(phase_of(c_MAX_W'(r_q), WIDTH, mode));
    assign q         = r_q;
    assign tick      = r_tick;
    assign wrap      = r_wrap;

    always_comb begin
        w_shift = r_q;
        case ({mode, dir})
            {MODE_JOHNSON, DIR_FWD}: w_shift = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            {MODE_JOHNSON, DIR_REV}: w_shift = {~r_q[0], r_q[WIDTH-1:1]};
            {MODE_RING, DIR_FWD}:    w_shift = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            default:                 w_shift = {r_q[0], r_q[WIDTH-1:1]};
        endcase

        // Boundary is judged on the phase being entered, not the one being left.
        w_next_phase = PH_W'(phase_of(c_MAX_W'(w_shift), WIDTH, mode));
        if (dir == DIR_FWD) begin
            w_next_wrap = (w_next_phase == '0);
        end else if (mode == MODE_RING) begin
            w_next_wrap = (w_next_phase == PH_W'(c_LAST_R));
        end else begin
            w_next_wrap = (w_next_phase == PH_W'(c_LAST_J));
        end

        w_load_q = is_legal(c_MAX_W'(load_val), WIDTH, mode) ? load_val : w_rst_val;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_q    <= w_rst_val;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= w_load_q;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_tick <= 1'b1;
            if (illegal) begin
                r_q    <= w_rst_val;
                r_wrap <= 1'b0;
            end else begin
                r_q    <= w_shift;
                r_wrap <= w_next_wrap;
            end
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jc_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_jc_seq_gen
// Description : Self-checking bench: directed vector table, corner sequences
//               and randomized traffic against a sequence-table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jc_seq_gen;

    localparam int W  = 8;
    localparam int DW = 8;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          en       = 1'b0;
    logic          dir      = 1'b0;
    logic          mode     = 1'b0;
    logic          load     = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [DW-1:0] div      = '0;
    logic [W-1:0]  q;
    logic [3:0]    phase;
    logic          tick;
    logic          wrap;
    logic          illegal;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_q;
    int           m_cnt;
    logic         m_tick;
    logic         m_wrap;

    typedef struct {
        logic         rst, en, dir, mode, load;
        logic [W-1:0] lv;
        logic [7:0]   dv;
        logic [W-1:0] eq;
        int           eph;
        logic         et, ew, ei;
    } vec_t;

    vec_t vecs[$];

    always #5 wb_clk_i = ~wb_clk_i;

    jc_seq_gen #(.WIDTH(W), .DIV_W(DW)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .div      (div),
        .q        (q),
        .phase    (phase),
        .tick     (tick),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    // Model: the legal sequence is listed by index; a step moves one index.
    function automatic logic [W-1:0] seq_val(input logic m, input int k);
        if (m) return W'(1 << k);
        if (k <= W) return W'((1 << k) - 1);
        return W'(((1 << W) - 1) ^ ((1 << (k - W)) - 1));
    endfunction

    function automatic int seq_len(input logic m);
        return m ? W : 2 * W;
    endfunction

    function automatic int find_phase(input logic [W-1:0] v, input logic m);
        for (int k = 0; k < seq_len(m); k++) begin
            if (seq_val(m, k) == v) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int p, np, n;
        logic st;
        n = seq_len(mode);
        if (wb_rst_i) begin
            m_q = seq_val(mode, 0); m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else if (load) begin
            m_q = (find_phase(load_val, mode) >= 0) ? load_val : seq_val(mode, 0);
            m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else begin
            st = en && (m_cnt == int'(div));
            if (en) m_cnt = st ? 0 : (m_cnt + 1) % (1 << DW);
            m_tick = st;
            m_wrap = 0;
            if (st) begin
                p = find_phase(m_q, mode);
                if (p < 0) begin
                    m_q = seq_val(mode, 0);
                end else begin
                    np = dir ? (p + n - 1) % n : (p + 1) % n;
                    m_q = seq_val(mode, np);
                    m_wrap = dir ? (np == n - 1) : (np == 0);
                end
            end
        end
    endtask

    task automatic cmp_model();
        int p;
        p = find_phase(m_q, mode);
        chk("model_q", q, m_q);
        chk("model_phase", phase, (p < 0) ? 0 : p);
        chk("model_tick", tick, m_tick);
        chk("model_wrap", wrap, m_wrap);
        chk("model_illegal", illegal, p < 0);
    endtask

    task automatic cycle();
        model_update();
        @(posedge wb_clk_i);
        #1;
        cmp_model();
    endtask

    task automatic set_in(input logic r, e, d, m, l, input logic [W-1:0] lv, input logic [7:0] dv);
        wb_rst_i = r; en = e; dir = d; mode = m; load = l; load_val = lv; div = dv;
    endtask

    function automatic vec_t mk(input logic r, e, d, m, l, input logic [W-1:0] lv, input logic [7:0] dv,
                                input logic [W-1:0] eq, input int eph, input logic et, ew, ei);
        vec_t t;
        t.rst = r; t.en = e; t.dir = d; t.mode = m; t.load = l; t.lv = lv; t.dv = dv;
        t.eq = eq; t.eph = eph; t.et = et; t.ew = ew; t.ei = ei;
        return t;
    endfunction

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] jfwd [16];

        jfwd = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, jfwd[i], (i + 1) % 16, 1, i == 15, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 8'h80, 15, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 0, 8'hC0, 14, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'hA5, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'h0F, 0, 8'h0F, 4, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 0, 8'h1F, 5, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h1F, 5, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 8'h00, 0, 8'h01, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 1, 0, 8'h00, 0, W'(1 << (i % 8)), i % 8, 1, i == 8, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rst, vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lv, vecs[i].dv);
            cycle();
            chk($sformatf("vec%0d_q", i), q, vecs[i].eq);
            chk($sformatf("vec%0d_phase", i), phase, vecs[i].eph);
            chk($sformatf("vec%0d_tick", i), tick, vecs[i].et);
            chk($sformatf("vec%0d_wrap", i), wrap, vecs[i].ew);
            chk($sformatf("vec%0d_illegal", i), illegal, vecs[i].ei);
        end

        // Ring at 04, then switch to Johnson: illegal until the next step corrects it.
        set_in(0, 1, 0, 1, 0, 8'h00, 0);
        cycle();
        cycle();
        chk("ring_at_04", q, 8'h04);
        en = 0; mode = 0;
        #1;
        chk("modechg_illegal", illegal, 1'b1);
        chk("modechg_phase", phase, 0);
        en = 1;
        cycle();
        chk("selfcorr_q", q, 8'h00);
        chk("selfcorr_tick", tick, 1'b1);
        chk("selfcorr_wrap", wrap, 1'b0);

        // Prescaler div=3 with an enable gap in mid-count.
        set_in(1, 0, 0, 0, 0, 8'h00, 3);
        cycle();
        wb_rst_i = 0; en = 1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            chk("div3_tick", tick, (i % 4) == 0);
        end
        held = q;
        en = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("gap_tick", tick, 1'b0);
            chk("gap_q_hold", q, held);
        end
        en = 1;
        cycle();
        chk("after_gap_tick3", tick, 1'b0);
        cycle();
        chk("after_gap_tick4", tick, 1'b1);

        // Reset beats a simultaneous load while the prescaler is mid-count.
        cycle();
        cycle();
        set_in(1, 1, 0, 0, 1, 8'h0F, 3);
        cycle();
        chk("rst_wins_q", q, 8'h00);
        chk("rst_wins_tick", tick, 1'b0);
        chk("rst_wins_wrap", wrap, 1'b0);
        wb_rst_i = 0; load = 0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("rst_cnt_cleared", tick, i == 4);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            wb_rst_i = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 24) == 0);
            load_val = $urandom_range(0, 1) ? W'($urandom)
                                            : seq_val(mode, $urandom_range(0, seq_len(mode) - 1));
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) dir  = ~dir;
            if ($urandom_range(0, 59) == 0) mode = ~mode;
            if ($urandom_range(0, 79) == 0) div  = 8'($urandom_range(0, 3));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jc_seq_gen.md
Name: jc_seq_gen

Overview:
Parametrised Johnson/ring sequence generator. It generalises the fixed 8-bit Johnson counter to any width, and adds:
- ring mode and up/down direction
- a programmable step prescaler
- parallel load with legalisation
- self-correction out of illegal states
- a decoded phase index plus tick and wrap strobes

It sits in the user project area, clocked from the Wishbone clock. q drives GPIO pads or LA probes; the control inputs come from LA or Wishbone registers.

Parameters:
WIDTH, 8, counter register width in bits (>= 2)
DIV_W, 8, prescaler divide-value width in bits (>= 1)
PH_W, $clog2(2*WIDTH), phase index width (derived; not overridden)

Ports:
wb_clk_i  input  1  single clock, all state on rising edge
wb_rst_i  input  1  synchronous active-high reset
en  input  1  count enable; 0 freezes prescaler and counter
dir  input  1  0 = forward (shift toward MSB), 1 = reverse
mode  input  1  0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states)
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value for load
div  input  DIV_W  step every div+1 enabled cycles
q  output  WIDTH  counter state (registered)
phase  output  PH_W  decoded state index
tick  output  1  registered pulse, high in the cycle q shows a stepped value
wrap  output  1  registered pulse, high with tick when the step crossed the sequence boundary
illegal  output  1  q is not a legal state for the current mode

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is synchronous and active-high.
- Priority per edge: reset > load > step > hold.
- Reset:
  - q = 0 if mode=0, else q = 1 (bit0 only); mode is sampled in the reset cycle.
  - Prescaler count = 0; tick = 0; wrap = 0.
- Prescaler:
  - 8-bit-style count cnt of width DIV_W.
  - When en=1 and cnt==div: step, and cnt <= 0.
  - When en=1 and cnt!=div: cnt <= cnt+1.
  - When en=0: cnt holds.
  - div=0 steps every enabled cycle.
  - If div is lowered below cnt, the next cycle with cnt!=div increments cnt, which wraps modulo 2^DIV_W; no special handling.
- Step rules:
  - Johnson fwd: q <= {q[W-2:0], ~q[W-1]}
  - Johnson rev: q <= {~q[0], q[W-1:1]}
  - Ring fwd: q <= {q[W-2:0], q[W-1]}
  - Ring rev: q <= {q[0], q[W-1:1]}
- Legal states:
  - Johnson: thermometer forms 0..01..1 or 1..10..0, including all-0 and all-1.
  - Ring: exactly one bit set.
- illegal: combinational from q and current mode.
- Self-correction: a step taken while illegal=1 sets q to the mode's reset value, tick=1, wrap=0.
- phase: combinational from q, no added latency.
  - Johnson, q[W-1]=0: phase = popcount(q).
  - Johnson, q[W-1]=1: phase = 2W - popcount(q).
  - Ring: phase = index of the set bit.
  - illegal: phase = 0.
- wrap:
  - Forward: asserted when the new phase is 0.
  - Reverse: asserted when the new phase is last (2W-1 for Johnson, W-1 for ring).
  - Never asserted on load or self-correction.
- Load:
  - q <= load_val if legal for the current mode, else the mode's reset value.
  - cnt <= 0; tick = 0; wrap = 0 in the following cycle.
- mode or dir changes take effect at the next step. A mode change may leave q illegal until that step.
- tick and wrap are single-cycle; both are 0 in every cycle without a step.
- Forward Johnson period = 2*WIDTH*(div+1) enabled cycles.

Decomposition:
- Shared package jc_pkg:
  - MODE_JOHNSON=1'b0, MODE_RING=1'b1, DIR_FWD=1'b0, DIR_REV=1'b1
  - functions: is_legal(q,mode), phase_of(q,mode), reset_val(mode)
- One sub-module, jc_prescaler:
  - inputs: clk, rst, en, div, clear (driven by load)
  - output: step pulse
- Next-state, legalisation and strobe registers stay in jc_seq_gen.

Test Plan:
1. WIDTH=8, mode=0, dir=0, div=0, en=1 after reset -> q steps 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; phase 1..15 then 0; wrap high only on the 00 step; tick high every cycle.
2. div=3, en held 1 except 5 cycles low mid-count -> tick every 4th enabled cycle; q and cnt frozen during en=0; the next tick lands exactly 4 enabled cycles after the previous one.
3. From q=00, dir=1 -> q=80, phase=15, wrap=1; next step q=C0, phase=14, wrap=0.
4. load=1, load_val=A5, mode=0 -> q=00, tick=0; then load_val=0F -> q=0F, phase=4, illegal=0; next step (fwd) -> q=1F.
5. Reset with mode=1 -> q=01; 8 fwd steps -> 02,04,...,80,01 with wrap on the 01 step. Then with q=04, set mode=0 -> illegal=1, phase=0; next step -> q=00, wrap=0, tick=1.
6. wb_rst_i=1 in the same cycle as load=1, en=1, cnt mid-count -> next edge q=00, cnt=0, tick=0, wrap=0 (reset wins).
